mult_hilo_unit: RTL and testbench

//  Multi-cycle integer multiplier with architectural HI/LO registers; consumer of the

---
 rtl/mult_hilo_unit.sv | 137 +++++++++++++
 tb/tb_mult_hilo_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_hilo_unit.sv
// mult_hilo_unit: iterative shift-add signed multiplier that owns the HI/LO
// architectural registers and stalls MFHI/MFLO while a product is in flight.
// Optional feature macro: MULT_UNSIGNED_EN adds the unsigned_op input (MULTU).
module mult_hilo_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef MULT_UNSIGNED_EN
    input  logic             unsigned_op,
`endif
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mf_req,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = $clog2(STEPS + 1);
    localparam int BPC   = BITS_PER_CYCLE;

    if (!((BPC == 1) || (BPC == 2) || (BPC == 4)) || (WIDTH % BPC != 0)) begin : g_bad_cfg
        $error("mult_hilo_unit: BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     mcand;
    logic                 neg;

    logic                 signed_op;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 neg_nxt;
    logic [WIDTH+BPC-1:0] upper;
    logic [2*WIDTH-1:0]   prod_step;
    logic [2*WIDTH-1:0]   prod_fix;

`ifdef MULT_UNSIGNED_EN
    assign signed_op = ~unsigned_op;
`else
    assign signed_op = 1'b1;
`endif

    assign busy  = (state != IDLE);
    assign stall = mf_req & busy;

    // Operand magnitudes and result sign; |most-negative| falls out as 2^(WIDTH-1) unsigned
    always_comb begin
        a_mag   = op_a;
        b_mag   = op_b;
        neg_nxt = 1'b0;
        if (signed_op) begin
            if (op_a[WIDTH-1]) a_mag = ~op_a + WIDTH'(1);
            if (op_b[WIDTH-1]) b_mag = ~op_b + WIDTH'(1);
            neg_nxt = op_a[WIDTH-1] ^ op_b[WIDTH-1];
        end
    end

    // One shift-add step: the multiplier lives in the low half of prod and is
    // consumed from the bottom while finished product bits shift in from the top
    always_comb begin
        upper     = {{BPC{1'b0}}, prod[2*WIDTH-1:WIDTH]}
                  + ({{BPC{1'b0}}, mcand} * {{WIDTH{1'b0}}, prod[BPC-1:0]});
        prod_step = {upper, prod[WIDTH-1:BPC]};
        prod_fix  = neg ? ((2*WIDTH)'(0) - prod) : prod;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: start always (re)enters RUN, abandoning or following the current op
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                if (start)         state_nxt = RUN;
                else if (cnt == 1) state_nxt = FIX;
            end
            FIX: state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: accumulate in RUN, commit HI/LO with done in FIX, reload on start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            prod  <= '0;
            mcand <= '0;
            neg   <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    prod <= prod_step;
                    cnt  <= cnt - CW'(1);
                end
                FIX: begin
                    hi   <= prod_fix[2*WIDTH-1:WIDTH];
                    lo   <= prod_fix[WIDTH-1:0];
                    done <= 1'b1;
                end
                default: ;
            endcase
            // Load after the RUN update so a restart overrides the in-flight step
            if (start) begin
                prod  <= {{WIDTH{1'b0}}, b_mag};
                mcand <= a_mag;
                neg   <= neg_nxt;
                cnt   <= CW'(STEPS);
            end
        end
    end

endmodule

// File: tb/tb_mult_hilo_unit.sv
// tb_mult_hilo_unit: directed vector table plus multi-cycle sequences
// (stall, restart, start-in-FIX, async reset abort) for mult_hilo_unit.
module tb_mult_hilo_unit;

    logic        clk;
    logic        rst_n;
    logic        unsigned_op;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        mf_req;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests;
    int fails;

    mult_hilo_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef MULT_UNSIGNED_EN
        .unsigned_op (unsigned_op),
`endif
        .start       (start),
        .op_a        (op_a),
        .op_b        (op_b),
        .mf_req      (mf_req),
        .busy        (busy),
        .stall       (stall),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        u;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge after the start edge (S0)
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic u);
        op_a        = a;
        op_b        = b;
        unsigned_op = u;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    // From S0, step negedges until done; also notes whether hi/lo moved early or stall misbehaved
    task automatic wait_done(input logic [31:0] old_hi, input logic [31:0] old_lo,
                             output int k, output logic held, output logic stall_ok);
        k        = 0;
        held     = 1'b1;
        stall_ok = 1'b1;
        do begin
            if (hi !== old_hi || lo !== old_lo) held = 1'b0;
            if (stall !== mf_req) stall_ok = 1'b0;
            @(negedge clk);
            #1;
            k++;
        end while (!done && k < 200);
    endtask

    initial begin
        int          k;
        logic        held;
        logic        sok;
        logic [31:0] oh;
        logic [31:0] ol;
        logic        early;

        tests       = 0;
        fails       = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        op_a        = '0;
        op_b        = '0;
        unsigned_op = 1'b0;
        mf_req      = 1'b0;

        vecs.push_back('{"3x5",        32'd3,        32'd5,        1'b0, 32'h0,        32'hF});
        vecs.push_back('{"m2x3",       32'hFFFFFFFE, 32'd3,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA});
        vecs.push_back('{"minxmin",    32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h0});
        vecs.push_back('{"minx1",      32'h80000000, 32'd1,        1'b0, 32'hFFFFFFFF, 32'h80000000});
        vecs.push_back('{"m1xm1",      32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h1});
        vecs.push_back('{"0xm5",       32'd0,        32'hFFFFFFFB, 1'b0, 32'h0,        32'h0});
        vecs.push_back('{"m7xm6",      32'hFFFFFFF9, 32'hFFFFFFFA, 1'b0, 32'h0,        32'd42});
        vecs.push_back('{"maxxmax",    32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 32'h3FFFFFFF, 32'h00000001});
        vecs.push_back('{"12345xm1",   32'd12345,    32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 32'hFFFFCFC7});
`ifdef MULT_UNSIGNED_EN
        vecs.push_back('{"u_ffxff",    32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001});
        vecs.push_back('{"u_minx2",    32'h80000000, 32'd2,        1'b1, 32'h1,        32'h0});
        vecs.push_back('{"s_ffxff",    32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h1});
`endif

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_hi",   hi,   0);
        chk("rst_lo",   lo,   0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        mf_req = 1'b1;
        #1;
        chk("idle_stall", stall, 0);
        mf_req = 1'b0;

        // Vector table: latency, busy, hold of old value, done pulse, result
        foreach (vecs[i]) begin
            oh = hi;
            ol = lo;
            issue(vecs[i].a, vecs[i].b, vecs[i].u);
            chk({vecs[i].name, "_busy"}, busy, 1);
            wait_done(oh, ol, k, held, sok);
            chk({vecs[i].name, "_lat"},  k,    33);
            chk({vecs[i].name, "_held"}, held, 1);
            chk({vecs[i].name, "_hi"},   hi,   vecs[i].hi);
            chk({vecs[i].name, "_lo"},   lo,   vecs[i].lo);
            chk({vecs[i].name, "_idle"}, busy, 0);
            @(negedge clk);
            chk({vecs[i].name, "_pulse"}, done, 0);
        end

        // MFLO issued right behind MULT 7*6: stall until the done cycle
        oh = hi;
        ol = lo;
        issue(32'd7, 32'd6, 1'b0);
        mf_req = 1'b1;
        #1;
        chk("mf_stall0", stall, 1);
        wait_done(oh, ol, k, held, sok);
        chk("mf_lat",       k,     33);
        chk("mf_stall_run", sok,   1);
        chk("mf_held",      held,  1);
        chk("mf_done_stall", stall, 0);
        chk("mf_lo",        lo,    42);
        mf_req = 1'b0;
        @(negedge clk);

        // Restart: 2*2 abandoned at cycle 10 by 9*9, no done for the first op
        issue(32'd2, 32'd2, 1'b0);
        early = 1'b0;
        repeat (9) begin
            @(negedge clk);
            if (done) early = 1'b1;
        end
        oh = hi;
        ol = lo;
        issue(32'd9, 32'd9, 1'b0);
        wait_done(oh, ol, k, held, sok);
        chk("rs_early", early, 0);
        chk("rs_lat",   k,     33);
        chk("rs_held",  held,  1);
        chk("rs_hi",    hi,    0);
        chk("rs_lo",    lo,    81);
        @(negedge clk);

        // Start during FIX: first op still commits, second follows on the same edge
        issue(32'd2, 32'd3, 1'b0);
        repeat (32) @(negedge clk);
        issue(32'd5, 32'd5, 1'b0);
        chk("fx_done", done, 1);
        chk("fx_lo",   lo,   6);
        chk("fx_busy", busy, 1);
        wait_done(32'd0, 32'd6, k, held, sok);
        chk("fx_lat",  k,    33);
        chk("fx_lo2",  lo,   25);
        @(negedge clk);

        // Async reset mid-operation
        issue(32'd9, 32'd9, 1'b0);
        repeat (4) @(negedge clk);
        mf_req = 1'b1;
        rst_n  = 1'b0;
        #1;
        chk("ar_hi",    hi,    0);
        chk("ar_lo",    lo,    0);
        chk("ar_busy",  busy,  0);
        chk("ar_stall", stall, 0);
        chk("ar_done",  done,  0);
        mf_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        early = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) early = 1'b1;
        end
        chk("ar_quiet", early, 0);
        chk("ar_lo2",   lo,    0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
